// File: rtl/riscy_pkg.sv
// Shared encodings for the RISCY fetch/next-PC sequencer and its helpers.
package riscy_pkg;

    // Opcode (instr[31:26]) and funct (instr[5:0]) values of interest
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // Program counter select encodings
    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    // Sequencer states
    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH     = 3'd0;
    localparam state_t ST_IMEM_WAIT = 3'd1;
    localparam state_t ST_DECODE    = 3'd2;
    localparam state_t ST_EXEC      = 3'd3;
    localparam state_t ST_UPDATE    = 3'd4;
    localparam state_t ST_HALT      = 3'd5;

    // Instruction classes as seen by next-PC and hazard logic
    typedef enum logic [2:0] {
        CLS_SEQ,
        CLS_JUMP,
        CLS_REG,
        CLS_BRANCH,
        CLS_HALT
    } insn_class_t;

    // Branch resolution from opcode and ALU zero flag; non-branches never take
    function automatic logic branch_taken(input logic [5:0] opcode, input logic zero);
        return ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
    endfunction

endpackage

// File: rtl/insn_classifier.sv
// Combinational instruction classifier shared by the sequencer and hazard logic.
module insn_classifier
    import riscy_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic [31:0]  instr,
    output insn_class_t  cls
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Priority order: jumps, register jump, branches, halt, then everything else
    always_comb begin
        cls = CLS_SEQ;
        if (opcode == OP_J || opcode == OP_JAL) begin
            cls = CLS_JUMP;
        end else if (opcode == OP_SPECIAL && funct == FUNCT_JR) begin
            cls = CLS_REG;
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            cls = CLS_BRANCH;
        end else if (opcode == HALT_OPCODE) begin
            cls = CLS_HALT;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch / decode / execute / next-PC controller for the RISCY core.
module pc_sequencer
    import riscy_pkg::*;
#(
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             exec_start,
    input  logic             exec_done,
    input  logic             alu_zero,
    output logic [1:0]       pc_ctrl,
    output logic             pc_write,
    output logic [25:0]      jump_address,
    output logic [15:0]      branch_offset,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count
);

    state_t            state_q, state_d;
    logic [31:0]       instr_q;
    insn_class_t       cls_q;
    insn_class_t       cls_dec;
    logic              taken_q;
    logic              exec_first_q;
    logic [CNT_W-1:0]  count_q;
    logic              fetch_hit;

    insn_classifier #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_classifier (
        .instr (instr_q),
        .cls   (cls_dec)
    );

    // A fetch completes when data arrives while a request is outstanding
    assign fetch_hit = imem_ready &&
                       ((state_q == ST_FETCH && !stall) || state_q == ST_IMEM_WAIT);

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (!stall) state_d = imem_ready ? ST_DECODE : ST_IMEM_WAIT;
            end
            ST_IMEM_WAIT: begin
                if (imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                unique case (cls_dec)
                    CLS_JUMP, CLS_REG: state_d = ST_UPDATE;
                    CLS_HALT:          state_d = ST_HALT;
                    default:           state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (exec_done) state_d = ST_UPDATE;
            end
            ST_UPDATE: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State, instruction latch, branch outcome and retirement counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            instr_q      <= '0;
            cls_q        <= CLS_SEQ;
            taken_q      <= 1'b0;
            exec_first_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            // Marks the first EXEC cycle so exec_start is a single pulse
            exec_first_q <= (state_q != ST_EXEC) && (state_d == ST_EXEC);
            if (fetch_hit) instr_q <= imem_rdata;
            if (state_q == ST_DECODE) begin
                cls_q   <= cls_dec;
                taken_q <= 1'b0;
            end
            if (state_q == ST_EXEC && exec_done) begin
                taken_q <= branch_taken(instr_q[31:26], alu_zero);
            end
            if (state_q == ST_UPDATE) count_q <= count_q + CNT_W'(1);
        end
    end

    // PC select is only meaningful during UPDATE; idle at PC_INC otherwise
    always_comb begin
        pc_ctrl = PC_INC;
        if (state_q == ST_UPDATE) begin
            unique case (cls_q)
                CLS_JUMP:   pc_ctrl = PC_JUMP;
                CLS_REG:    pc_ctrl = PC_REG;
                CLS_BRANCH: pc_ctrl = taken_q ? PC_BRANCH : PC_INC;
                default:    pc_ctrl = PC_INC;
            endcase
        end
    end

    // Request is gated by reset so no fetch is visible while reset is held
    assign imem_req = reset &&
                      ((state_q == ST_FETCH && !stall) || state_q == ST_IMEM_WAIT);

    assign exec_start    = (state_q == ST_EXEC) && exec_first_q;
    assign pc_write      = (state_q == ST_UPDATE);
    assign halted        = (state_q == ST_HALT);
    assign instr         = instr_q;
    assign jump_address  = instr_q[25:0];
    assign branch_offset = instr_q[15:0];
    assign retired_count = count_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/next-PC controller for the RISCY core.
- Fetches one instruction per pass over the instruction-memory handshake and classifies it: sequential, jump, branch, register-jump or halt.
- Sequences the execute step and resolves branch outcome.
- Drives the program counter's 2-bit control select plus a one-cycle PC write strobe, so the PC advances exactly once per retired instruction.

Parameters:
- HALT_OPCODE, 6'b111111, opcode that parks the sequencer in HALT
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk)
- stall  in  1  hazard hold; suppresses issue of a new fetch
- imem_req  out  1  instruction fetch request; address is current PC
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched instruction register
- exec_start  out  1  one-cycle pulse: datapath begins execute
- exec_done  in  1  datapath execute complete
- alu_zero  in  1  ALU zero flag, valid when exec_done=1
- pc_ctrl  out  2  00 +4, 01 jump, 10 register, 11 branch
- pc_write  out  1  one-cycle PC update strobe
- jump_address  out  26  instr[25:0]
- branch_offset  out  16  instr[15:0]
- halted  out  1  sequencer parked in HALT
- retired_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (reset=0 at posedge):
  - state=FETCH; instr=0; retired_count=0; taken=0.
  - All strobes (imem_req, exec_start, pc_write) low; pc_ctrl=00; halted=0.
  - Reset mid-operation aborts any outstanding fetch or execute immediately; no pc_write is issued.
- States: FETCH, IMEM_WAIT, DECODE, EXEC, UPDATE, HALT.
- FETCH:
  - If stall=1: imem_req=0 and remain in FETCH.
  - Else imem_req=1. If imem_ready=1 in the same cycle, latch instr and go to DECODE (zero-wait fetch). Otherwise go to IMEM_WAIT.
- IMEM_WAIT:
  - imem_req held at 1 regardless of stall.
  - On imem_ready=1: latch instr, go to DECODE.
- DECODE (classify instr[31:26]/instr[5:0]):
  - J (000010) or JAL (000011): class jump, go to UPDATE.
  - opcode 000000 with funct 001000 (JR): class register, go to UPDATE.
  - BEQ (000100) or BNE (000101): class branch, go to EXEC.
  - HALT_OPCODE: go to HALT, no PC update.
  - Anything else: class sequential, go to EXEC.
- EXEC:
  - exec_start=1 on the entry cycle only.
  - Wait for exec_done. exec_done may arrive on the entry cycle; exec_done outside EXEC is ignored.
  - On exec_done: taken = (BEQ & alu_zero) | (BNE & ~alu_zero). Go to UPDATE.
- UPDATE (exactly one cycle):
  - pc_write=1 and retired_count+=1.
  - pc_ctrl: jump→01, register→10, taken branch→11, otherwise 00.
  - Go to FETCH.
- pc_ctrl is 00 in every state except UPDATE.
- HALT: sticky, halted=1, all strobes low; only reset exits.
- jump_address and branch_offset are continuous slices of instr; they are stable from DECODE through UPDATE.
- retired_count wraps modulo 2^CNT_W with no saturation.
- Minimum pass lengths:
  - Jump: FETCH→DECODE→UPDATE, 3 cycles.
  - ALU/branch with 1-cycle execute: 4 cycles.

Decomposition:
- Shared package riscy_pkg:
  - opcode/funct constants (J, JAL, BEQ, BNE, SPECIAL, JR funct)
  - pc_ctrl encodings PC_INC, PC_JUMP, PC_REG, PC_BRANCH
  - state enum, instruction-class enum
- Natural sub-module insn_classifier: purely combinational, instr → class. It is reused by hazard logic.

Test Plan:
- Reset low for 2 cycles, release; imem_ready=1 immediately, instr=ADD → req at cycle 0, exec_start at cycle 2, exec_done same cycle, pc_write with pc_ctrl=00 at cycle 3, retired_count=1.
- instr=0x08000010 (J) with 3-cycle imem latency → req held 3 cycles, no exec_start, UPDATE pc_ctrl=01, jump_address=0x0000010.
- BEQ offset 0xFFFF with alu_zero=1 → pc_ctrl=11, branch_offset=0xFFFF. Repeat with alu_zero=0 → pc_ctrl=00. BNE gives the inverse outcomes.
- stall=1 for 4 cycles in FETCH → imem_req=0 throughout. Raise stall after req issued in IMEM_WAIT → req stays 1 until ready.
- instr opcode 111111 → halted=1, no pc_write for 20 cycles despite imem_ready/exec_done toggling. reset low → FETCH, halted=0.
- Assert reset during EXEC (exec_done pending) → next cycle state FETCH, no pc_write, retired_count=0.
